// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII register-access UART encoder and decoder:
// state encodings, frame types, ASCII constants and frame lengths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_STOP = 2'd2
    } enc_state_e;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_FAIL  = 2'd1,
        FR_READ  = 2'd2,
        FR_WRITE = 2'd3
    } frame_e;

    localparam logic [7:0] ASC_R      = 8'h52;
    localparam logic [7:0] ASC_W      = 8'h57;
    localparam logic [7:0] ASC_F      = 8'h46;
    localparam logic [7:0] ASC_CR     = 8'h0D;
    localparam logic [7:0] ASC_LF     = 8'h0A;
    localparam logic [7:0] ASC_DIGIT0 = 8'h30;
    localparam logic [7:0] ASC_ALPHA_A = 8'h41;

    // Frame body lengths (type char plus hex chars), terminator excluded.
    localparam logic [3:0] LEN_FAIL  = 4'd1;
    localparam logic [3:0] LEN_READ  = 4'd11;
    localparam logic [3:0] LEN_WRITE = 4'd3;
    localparam logic [3:0] LEN_EOL   = 4'd2;

    function automatic logic [3:0] body_len(input frame_e t);
        case (t)
            FR_READ:  body_len = LEN_READ;
            FR_WRITE: body_len = LEN_WRITE;
            default:  body_len = LEN_FAIL;
        endcase
    endfunction

    function automatic logic [3:0] frame_len(input frame_e t, input bit eol);
        frame_len = body_len(t) + (eol ? LEN_EOL : 4'd0);
    endfunction

endpackage

// File: rtl/uart_hex2asc.sv
// Combinational nibble to uppercase ASCII hex character converter.
module uart_hex2asc
    import uart_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] asc_o
);

    always_comb begin
        if (nib_i < 4'd10) begin
            asc_o = ASC_DIGIT0 + {4'h0, nib_i};
        end else begin
            asc_o = ASC_ALPHA_A + {4'h0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_enc.sv
// Frame encoder: turns a read/write/fail response request into an ASCII byte
// stream ('R'/'W'/'F', hex address/data, optional CR LF) on a valid/ready sink.
module uart_enc
    import uart_pkg::*;
#(
    parameter bit EOL_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        STATE_R_IN,
    input  logic        STATE_W_IN,
    input  logic        FAIL_IN,
    input  logic [7:0]  ADDR_IN,
    input  logic [31:0] DATA_IN,
    input  logic        TX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        BUSY,
    output logic        DONE
);

    enc_state_e  state_q, state_d;
    frame_e      type_q, type_d, req_type;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  nib;
    logic [3:0]  body;
    logic [3:0]  last_idx;
    logic [7:0]  hex_asc;
    logic [7:0]  byte_sel;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            type_q  <= FR_NONE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        if (FAIL_IN)                    req_type = FR_FAIL;
        else if (STATE_R_IN && !STATE_W_IN) req_type = FR_READ;
        else if (STATE_W_IN && !STATE_R_IN) req_type = FR_WRITE;
        else                            req_type = FR_NONE;
    end

    // Index 1-2 select address nibbles, 3-10 data nibbles, MS nibble first.
    always_comb begin
        case (idx_q)
            4'd1:    nib = addr_q[7:4];
            4'd2:    nib = addr_q[3:0];
            4'd3:    nib = data_q[31:28];
            4'd4:    nib = data_q[27:24];
            4'd5:    nib = data_q[23:20];
            4'd6:    nib = data_q[19:16];
            4'd7:    nib = data_q[15:12];
            4'd8:    nib = data_q[11:8];
            4'd9:    nib = data_q[7:4];
            4'd10:   nib = data_q[3:0];
            default: nib = '0;
        endcase
    end

    uart_hex2asc u_hex2asc (
        .nib_i (nib),
        .asc_o (hex_asc)
    );

    assign body     = body_len(type_q);
    assign last_idx = frame_len(type_q, EOL_EN) - 4'd1;

    always_comb begin
        if (idx_q == 4'd0) begin
            case (type_q)
                FR_READ:  byte_sel = ASC_R;
                FR_WRITE: byte_sel = ASC_W;
                default:  byte_sel = ASC_F;
            endcase
        end else if (idx_q < body) begin
            byte_sel = hex_asc;
        end else if (idx_q == body) begin
            byte_sel = ASC_CR;
        end else begin
            byte_sel = ASC_LF;
        end
    end

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        data_d   = data_q;
        TX_DATA  = '0;
        TX_VALID = 1'b0;
        BUSY     = 1'b1;
        DONE     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                BUSY = 1'b0;
                if (START && req_type != FR_NONE) begin
                    state_d = ST_SEND;
                    type_d  = req_type;
                    addr_d  = ADDR_IN;
                    data_d  = DATA_IN;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                TX_VALID = 1'b1;
                TX_DATA  = byte_sel;
                if (TX_READY) begin
                    if (idx_q == last_idx) begin
                        state_d = ST_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
                type_d  = FR_NONE;
                idx_d   = '0;
                addr_d  = '0;
                data_d  = '0;
            end
            default: begin
                state_d = ST_IDLE;
                type_d  = FR_NONE;
                idx_d   = '0;
                addr_d  = '0;
                data_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_enc.sv
// Directed self-checking bench for uart_enc (EOL_EN=1 and EOL_EN=0 builds).
module tb_uart_enc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        STATE_R_IN;
    logic        STATE_W_IN;
    logic        FAIL_IN;
    logic [7:0]  ADDR_IN;
    logic [31:0] DATA_IN;
    logic        TX_READY;
    logic [7:0]  TX_DATA,  ne_TX_DATA;
    logic        TX_VALID, ne_TX_VALID;
    logic        BUSY,     ne_BUSY;
    logic        DONE,     ne_DONE;

    int checks   = 0;
    int failures = 0;

    uart_enc #(.EOL_EN(1'b1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STATE_R_IN(STATE_R_IN),
        .STATE_W_IN(STATE_W_IN), .FAIL_IN(FAIL_IN), .ADDR_IN(ADDR_IN),
        .DATA_IN(DATA_IN), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .BUSY(BUSY), .DONE(DONE)
    );

    uart_enc #(.EOL_EN(1'b0)) dut_ne (
        .CLK(CLK), .RST(RST), .START(START), .STATE_R_IN(STATE_R_IN),
        .STATE_W_IN(STATE_W_IN), .FAIL_IN(FAIL_IN), .ADDR_IN(ADDR_IN),
        .DATA_IN(DATA_IN), .TX_READY(TX_READY), .TX_DATA(ne_TX_DATA),
        .TX_VALID(ne_TX_VALID), .BUSY(ne_BUSY), .DONE(ne_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input bit f, input bit r, input bit w,
                           input logic [7:0] a, input logic [31:0] d);
        FAIL_IN = f; STATE_R_IN = r; STATE_W_IN = w;
        ADDR_IN = a; DATA_IN = d;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    // Streams one frame from the EOL_EN=1 instance, checking every presented
    // byte; optionally toggles ready and injects a second START mid-frame.
    task automatic run_frame(input string tag, input string body, input bit toggle,
                             input int inject_at, output int busy_cycles);
        logic [7:0] exp[$];
        int idx = 0;
        int cyc = 0;
        bit rdy = 1'b1;
        for (int i = 0; i < body.len(); i++) exp.push_back(body[i]);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        busy_cycles = 0;
        while (idx < exp.size() && cyc < 100) begin
            TX_READY = rdy;
            chk({tag, "_valid"}, {31'd0, TX_VALID}, 32'd1);
            chk({tag, "_data"}, {24'd0, TX_DATA}, {24'd0, exp[idx]});
            if (BUSY) busy_cycles++;
            if (cyc == inject_at) begin
                START = 1'b1; FAIL_IN = 1'b1; STATE_W_IN = 1'b1; STATE_R_IN = 1'b0;
                ADDR_IN = 8'hFF; DATA_IN = 32'hFFFF_FFFF;
            end else begin
                START = 1'b0;
            end
            if (rdy) idx++;
            tick();
            cyc++;
            if (toggle) rdy = ~rdy;
        end
        START = 1'b0;
        TX_READY = 1'b1;
        chk({tag, "_timeout"}, {31'd0, cyc >= 100}, 32'd0);
        chk({tag, "_done"}, {31'd0, DONE}, 32'd1);
        chk({tag, "_stop_valid"}, {31'd0, TX_VALID}, 32'd0);
        if (BUSY) busy_cycles++;
        tick();
        chk({tag, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_idle_done"}, {31'd0, DONE}, 32'd0);
    endtask

    initial begin
        int bc;
        RST = 1'b1; START = 1'b0; STATE_R_IN = 1'b0; STATE_W_IN = 1'b0;
        FAIL_IN = 1'b0; ADDR_IN = '0; DATA_IN = '0; TX_READY = 1'b1;
        #3;
        chk("rst_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rst_data",  {24'd0, TX_DATA}, 32'd0);
        chk("rst_busy",  {31'd0, BUSY}, 32'd0);
        chk("rst_done",  {31'd0, DONE}, 32'd0);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Read frame, ready always high
        request(1'b0, 1'b1, 1'b0, 8'h3A, 32'hDEAD_BEEF);
        run_frame("read", "R3ADEADBEEF", 1'b0, -1, bc);
        chk("read_busy_cycles", bc, 32'd14);

        // Write frame, ready toggling
        request(1'b0, 1'b0, 1'b1, 8'h05, 32'h1234_5678);
        run_frame("write_tog", "W05", 1'b1, -1, bc);

        // Fail has priority over read; EOL_EN=0 build sends only 'F'
        request(1'b1, 1'b1, 1'b0, 8'h77, 32'h0);
        chk("fail_b0", {24'd0, TX_DATA}, 32'h46);
        chk("ne_fail_b0", {24'd0, ne_TX_DATA}, 32'h46);
        chk("ne_fail_valid", {31'd0, ne_TX_VALID}, 32'd1);
        tick();
        chk("fail_b1", {24'd0, TX_DATA}, 32'h0D);
        chk("ne_fail_done", {31'd0, ne_DONE}, 32'd1);
        chk("ne_fail_stop_valid", {31'd0, ne_TX_VALID}, 32'd0);
        tick();
        chk("fail_b2", {24'd0, TX_DATA}, 32'h0A);
        chk("ne_fail_idle", {31'd0, ne_BUSY}, 32'd0);
        tick();
        chk("fail_done", {31'd0, DONE}, 32'd1);
        tick();
        chk("fail_idle", {31'd0, BUSY}, 32'd0);

        // Invalid requests: R=W=1, then no flags
        request(1'b0, 1'b1, 1'b1, 8'h11, 32'h1);
        chk("rw_valid", {31'd0, TX_VALID}, 32'd0);
        chk("rw_busy",  {31'd0, BUSY}, 32'd0);
        tick();
        chk("rw_done",  {31'd0, DONE}, 32'd0);
        request(1'b0, 1'b0, 1'b0, 8'h11, 32'h1);
        chk("none_valid", {31'd0, TX_VALID}, 32'd0);
        chk("none_busy",  {31'd0, BUSY}, 32'd0);
        tick();
        chk("none_done",  {31'd0, DONE}, 32'd0);

        // Reset after the 4th byte of a read frame
        request(1'b0, 1'b1, 1'b0, 8'h9C, 32'hCAFE_F00D);
        tick(); tick(); tick(); tick();
        chk("prerst_data", {24'd0, TX_DATA}, 32'h41);
        RST = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, TX_VALID}, 32'd0);
        chk("midrst_data",  {24'd0, TX_DATA}, 32'd0);
        chk("midrst_busy",  {31'd0, BUSY}, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        chk("postrst_valid", {31'd0, TX_VALID}, 32'd0);
        request(1'b0, 1'b0, 1'b1, 8'hC7, 32'h0);
        run_frame("write_after_rst", "WC7", 1'b0, -1, bc);

        // Second START during SEND is dropped
        request(1'b0, 1'b1, 1'b0, 8'h12, 32'h0123_4567);
        run_frame("read_inject", "R1201234567", 1'b0, 3, bc);
        tick();
        chk("inject_dropped_valid", {31'd0, TX_VALID}, 32'd0);
        chk("inject_dropped_busy",  {31'd0, BUSY}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
